// File: rtl/pc_pkg.sv
// Shared types for the program-counter sequencer:
// FSM state encoding, redirect source and step size.
package pc_pkg;

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      HALT
   } state_e;

   typedef enum logic [2:0] {
      SEQ,
      BR,
      J,
      JR,
      EXC
   } src_e;

   function automatic int unsigned step_of(input int unsigned align);
      return 32'd1 << align;
   endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC candidates: sequential, branch, region jump,
// plus the alignment check on a register target.
module pc_target_calc
   import pc_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int REGION_BITS = 4,
   parameter int ALIGN_BITS  = 2,
   parameter int IMM_WIDTH   = 16
) (
   input  logic [ADDR_WIDTH-1:0]                        pc,
   input  logic [IMM_WIDTH-1:0]                         branch_offset,
   input  logic [ADDR_WIDTH-REGION_BITS-ALIGN_BITS-1:0] jump_index,
   input  logic [ADDR_WIDTH-1:0]                        jr_target,
   output logic [ADDR_WIDTH-1:0]                        seq_pc,
   output logic [ADDR_WIDTH-1:0]                        br_pc,
   output logic [ADDR_WIDTH-1:0]                        jmp_pc,
   output logic                                         jr_misaligned
);

   localparam int unsigned STEP = step_of(ALIGN_BITS);

   logic [ADDR_WIDTH-1:0] off_ext;

   always_comb begin
      off_ext = {{(ADDR_WIDTH-IMM_WIDTH){branch_offset[IMM_WIDTH-1]}},
                 branch_offset};
      seq_pc  = pc + ADDR_WIDTH'(STEP);
      br_pc   = seq_pc + (off_ext << ALIGN_BITS);
      // region comes from the sequential pc, not the current one
      jmp_pc  = {seq_pc[ADDR_WIDTH-1 -: REGION_BITS], jump_index,
                 {ALIGN_BITS{1'b0}}};
      jr_misaligned = |jr_target[ALIGN_BITS-1:0];
   end

endmodule

// File: rtl/pc_sequencer.sv
// Registered PC with fetch handshake, redirect selection,
// EPC capture and BOOT/RUN/HALT control.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int REGION_BITS = 4,
   parameter int ALIGN_BITS  = 2,
   parameter int IMM_WIDTH   = 16,
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 32'h0040_0000,
   parameter logic [ADDR_WIDTH-1:0] EXC_VECTOR   = 32'h8000_0180
) (
   input  logic                                         clk,
   input  logic                                         rst_n,
   output logic [ADDR_WIDTH-1:0]                        pc,
   output logic                                         pc_valid,
   input  logic                                         pc_ready,
   input  logic                                         branch_en,
   input  logic [IMM_WIDTH-1:0]                         branch_offset,
   input  logic                                         jump_en,
   input  logic [ADDR_WIDTH-REGION_BITS-ALIGN_BITS-1:0] jump_index,
   input  logic                                         jr_en,
   input  logic [ADDR_WIDTH-1:0]                        jr_target,
   input  logic                                         exc_en,
   input  logic                                         halt_req,
   input  logic                                         resume,
   output logic [ADDR_WIDTH-1:0]                        epc,
   output logic                                         misalign_err,
   output logic                                         redirect_taken
);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [ADDR_WIDTH-1:0] epc_q, epc_d;
   logic                  mis_q, mis_d;
   logic                  redir_q, redir_d;

   logic [ADDR_WIDTH-1:0] seq_pc, br_pc, jmp_pc;
   logic                  jr_mis;
   logic                  advance;
   logic                  upd;
   src_e                  src;

   pc_target_calc #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .REGION_BITS (REGION_BITS),
      .ALIGN_BITS  (ALIGN_BITS),
      .IMM_WIDTH   (IMM_WIDTH)
   ) u_calc (
      .pc            (pc_q),
      .branch_offset (branch_offset),
      .jump_index    (jump_index),
      .jr_target     (jr_target),
      .seq_pc        (seq_pc),
      .br_pc         (br_pc),
      .jmp_pc        (jmp_pc),
      .jr_misaligned (jr_mis)
   );

   assign pc_valid = (state_q == RUN);
   assign advance  = pc_valid & pc_ready;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      epc_d   = epc_q;
      mis_d   = 1'b0;
      redir_d = 1'b0;
      upd     = 1'b0;
      src     = SEQ;

      unique case (state_q)
         BOOT: state_d = RUN;
         RUN: begin
            if (exc_en) begin
               upd = 1'b1;
               src = EXC;
            end else if (advance) begin
               upd = 1'b1;
               if (jr_en && jr_mis) begin
                  src   = EXC;
                  mis_d = 1'b1;
               end else if (jr_en) begin
                  src = JR;
               end else if (jump_en) begin
                  src = J;
               end else if (branch_en) begin
                  src = BR;
               end else begin
                  src = SEQ;
               end
            end
            if (halt_req && src != EXC) state_d = HALT;
         end
         HALT: begin
            if (exc_en) begin
               upd     = 1'b1;
               src     = EXC;
               state_d = RUN;
            end else if (resume) begin
               state_d = RUN;
            end
         end
         default: state_d = BOOT;
      endcase

      if (upd) begin
         unique case (src)
            EXC: begin
               pc_d  = EXC_VECTOR;
               epc_d = pc_q;
            end
            JR:      pc_d = jr_target;
            J:       pc_d = jmp_pc;
            BR:      pc_d = br_pc;
            default: pc_d = seq_pc;
         endcase
         redir_d = (src != SEQ);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= BOOT;
         pc_q    <= RESET_VECTOR;
         epc_q   <= '0;
         mis_q   <= 1'b0;
         redir_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         epc_q   <= epc_d;
         mis_q   <= mis_d;
         redir_q <= redir_d;
      end
   end

   assign pc             = pc_q;
   assign epc            = epc_q;
   assign misalign_err   = mis_q;
   assign redirect_taken = redir_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed vector bench for pc_sequencer: handshake stepping,
// redirects, exceptions, halt/resume, wrap and async reset.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc;
   logic        pc_valid;
   logic        pc_ready;
   logic        branch_en;
   logic [15:0] branch_offset;
   logic        jump_en;
   logic [25:0] jump_index;
   logic        jr_en;
   logic [31:0] jr_target;
   logic        exc_en;
   logic        halt_req;
   logic        resume;
   logic [31:0] epc;
   logic        misalign_err;
   logic        redirect_taken;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pc_sequencer dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .pc             (pc),
      .pc_valid       (pc_valid),
      .pc_ready       (pc_ready),
      .branch_en      (branch_en),
      .branch_offset  (branch_offset),
      .jump_en        (jump_en),
      .jump_index     (jump_index),
      .jr_en          (jr_en),
      .jr_target      (jr_target),
      .exc_en         (exc_en),
      .halt_req       (halt_req),
      .resume         (resume),
      .epc            (epc),
      .misalign_err   (misalign_err),
      .redirect_taken (redirect_taken)
   );

   typedef struct {
      logic        rdy;
      logic        br;
      logic [15:0] boff;
      logic        j;
      logic [25:0] jidx;
      logic        jr;
      logic [31:0] jrt;
      logic        exc;
      logic        halt;
      logic        res;
      logic [31:0] e_pc;
      logic        e_val;
      logic [31:0] e_epc;
      logic        e_mis;
      logic        e_red;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      pc_ready      = 1'b0;
      branch_en     = 1'b0;
      branch_offset = '0;
      jump_en       = 1'b0;
      jump_index    = '0;
      jr_en         = 1'b0;
      jr_target     = '0;
      exc_en        = 1'b0;
      halt_req      = 1'b0;
      resume        = 1'b0;
   endtask

   initial begin
      // rdy br boff j jidx jr jrt exc halt res | pc val epc mis red
      vecs.push_back('{1,0,16'h0,0,26'h0,0,32'h0,0,0,0, 32'h0040_0000,1,32'h0,0,0});
      vecs.push_back('{1,0,16'h0,0,26'h0,0,32'h0,0,0,0, 32'h0040_0004,1,32'h0,0,0});
      vecs.push_back('{1,0,16'h0,0,26'h0,0,32'h0,0,0,0, 32'h0040_0008,1,32'h0,0,0});
      vecs.push_back('{1,0,16'h0,0,26'h0,0,32'h0,0,0,0, 32'h0040_000C,1,32'h0,0,0});
      vecs.push_back('{1,0,16'h0,0,26'h0,1,32'h0040_0010,0,0,0, 32'h0040_0010,1,32'h0,0,1});
      vecs.push_back('{1,0,16'h0,0,26'h0,1,32'h0040_0102,0,0,0, 32'h8000_0180,1,32'h0040_0010,1,1});
      vecs.push_back('{0,0,16'h0,0,26'h0,0,32'h0,0,0,0, 32'h8000_0180,1,32'h0040_0010,0,0});
      vecs.push_back('{1,0,16'h0,0,26'h0,1,32'h0040_0020,0,0,0, 32'h0040_0020,1,32'h0040_0010,0,1});
      vecs.push_back('{0,0,16'h0,0,26'h0,0,32'h0,1,0,0, 32'h8000_0180,1,32'h0040_0020,0,1});
      vecs.push_back('{1,0,16'h0,0,26'h0,1,32'h1FFF_FFFC,0,0,0, 32'h1FFF_FFFC,1,32'h0040_0020,0,1});
      vecs.push_back('{1,0,16'h0,1,26'h10,0,32'h0,0,0,0, 32'h2000_0040,1,32'h0040_0020,0,1});
      vecs.push_back('{1,0,16'h0,0,26'h0,1,32'h0040_0040,0,0,0, 32'h0040_0040,1,32'h0040_0020,0,1});
      vecs.push_back('{1,1,16'hFFFF,0,26'h0,0,32'h0,0,0,0, 32'h0040_0040,1,32'h0040_0020,0,1});
      vecs.push_back('{0,1,16'h0010,0,26'h0,0,32'h0,0,0,0, 32'h0040_0040,1,32'h0040_0020,0,0});
      vecs.push_back('{1,1,16'h0004,0,26'h0,0,32'h0,0,0,0, 32'h0040_0054,1,32'h0040_0020,0,1});
      vecs.push_back('{1,1,16'h0005,1,26'h3,1,32'h0040_0100,0,0,0, 32'h0040_0100,1,32'h0040_0020,0,1});
      vecs.push_back('{1,1,16'h0005,1,26'h3,0,32'h0,0,0,0, 32'h0000_000C,1,32'h0040_0020,0,1});
      vecs.push_back('{1,0,16'h0,0,26'h0,1,32'hFFFF_FFFC,0,0,0, 32'hFFFF_FFFC,1,32'h0040_0020,0,1});
      vecs.push_back('{1,0,16'h0,0,26'h0,0,32'h0,0,0,0, 32'h0000_0000,1,32'h0040_0020,0,0});
      vecs.push_back('{1,0,16'h0,0,26'h0,0,32'h0,1,1,0, 32'h8000_0180,1,32'h0000_0000,0,1});
      vecs.push_back('{1,0,16'h0,0,26'h0,1,32'h0040_0000,0,0,0, 32'h0040_0000,1,32'h0,0,1});
      vecs.push_back('{1,0,16'h0,0,26'h0,0,32'h0,0,1,0, 32'h0040_0004,0,32'h0,0,0});
      for (int k = 0; k < 5; k++)
         vecs.push_back('{1,1,16'h0010,0,26'h0,0,32'h0,0,0,0, 32'h0040_0004,0,32'h0,0,0});
      vecs.push_back('{0,0,16'h0,0,26'h0,0,32'h0,0,0,1, 32'h0040_0004,1,32'h0,0,0});
      vecs.push_back('{0,0,16'h0,0,26'h0,0,32'h0,0,1,0, 32'h0040_0004,0,32'h0,0,0});
      vecs.push_back('{0,0,16'h0,0,26'h0,0,32'h0,1,0,0, 32'h8000_0180,1,32'h0040_0004,0,1});

      idle_inputs();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_pc",    pc,             32'h0040_0000);
      chk("rst_valid", {31'b0, pc_valid}, 32'd0);
      chk("rst_epc",   epc,            32'h0);
      chk("rst_mis",   {31'b0, misalign_err}, 32'd0);
      chk("rst_red",   {31'b0, redirect_taken}, 32'd0);

      foreach (vecs[i]) begin
         pc_ready      = vecs[i].rdy;
         branch_en     = vecs[i].br;
         branch_offset = vecs[i].boff;
         jump_en       = vecs[i].j;
         jump_index    = vecs[i].jidx;
         jr_en         = vecs[i].jr;
         jr_target     = vecs[i].jrt;
         exc_en        = vecs[i].exc;
         halt_req      = vecs[i].halt;
         resume        = vecs[i].res;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
         chk($sformatf("v%0d_valid", i), {31'b0, pc_valid},
             {31'b0, vecs[i].e_val});
         chk($sformatf("v%0d_epc", i), epc, vecs[i].e_epc);
         chk($sformatf("v%0d_mis", i), {31'b0, misalign_err},
             {31'b0, vecs[i].e_mis});
         chk($sformatf("v%0d_red", i), {31'b0, redirect_taken},
             {31'b0, vecs[i].e_red});
         @(negedge clk);
      end

      // advance once, then drop reset between clock edges
      idle_inputs();
      pc_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("pre_rst_pc", pc, 32'h8000_0184);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_pc",    pc,  32'h0040_0000);
      chk("async_epc",   epc, 32'h0);
      chk("async_valid", {31'b0, pc_valid}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_valid", {31'b0, pc_valid}, 32'd1);
      chk("post_rst_pc",    pc, 32'h0040_0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
